// File: rtl/huff_pkg.sv
// Shared types and helpers for the Huffman code-word builder.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package huff_pkg;

    // Top-level sequencing: waiting for a table, accumulating merges, table ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        DONE  = 2'd2
    } hcb_state_t;

    // Width needed to hold a code length in the range 0..max_len
    function automatic int len_w_of(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Defaults used by the block when not overridden
    localparam int HCB_DEF_NUM_SYM = 6;
    localparam int HCB_DEF_MAX_LEN = 8;
    localparam int HCB_DEF_LEN_W   = len_w_of(HCB_DEF_MAX_LEN);

    // Bit offset of lane idx inside a flat bus of width-bit lanes
    function automatic int flat_off(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/huff_code_lane.sv
// One symbol lane: accumulates code word, valid-bit mask and length (HCB_PREPEND_EN picks insert-at-len).
// Latency: update visible one cycle after upd; ovf is a same-cycle combinational pulse.
// Backpressure: none; the lane accepts an update every cycle, saturating at MAX_LEN.
module huff_code_lane
    import huff_pkg::*;
#(
    parameter int MAX_LEN = HCB_DEF_MAX_LEN,
    parameter int LEN_W   = len_w_of(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               upd,
    input  logic               sel_l,
    input  logic               sel_s,
    output logic [MAX_LEN-1:0] code,
    output logic [MAX_LEN-1:0] mask,
    output logic [LEN_W-1:0]   len,
    output logic               ovf
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic               sel;
    logic               new_bit;
    logic               full;
    logic               grow;
    logic [MAX_LEN-1:0] code_nxt;

    // Decide whether this lane grows, saturates, or holds; build the next code word
    always_comb begin
        sel      = sel_l | sel_s;
        // long subtree appends 0 and wins when both masks select the lane
        new_bit  = ~sel_l;
        full     = (len == LEN_MAX);
        ovf      = upd & sel & full;
        grow     = upd & sel & ~full;
        code_nxt = code;
`ifdef HCB_PREPEND_EN
        // bits above len are always zero, so placing the new bit at len is enough
        for (int j = 0; j < MAX_LEN; j++) begin
            if (LEN_W'(j) == len) begin
                code_nxt[j] = new_bit;
            end
        end
`else
        code_nxt = {code[MAX_LEN-2:0], new_bit};
`endif
    end

    // Lane registers: reset/clear to empty, otherwise grow by one bit when selected
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            code <= '0;
            mask <= '0;
            len  <= '0;
        end else if (grow) begin
            code <= code_nxt;
            mask <= {mask[MAX_LEN-2:0], 1'b1};
            len  <= len + LEN_W'(1);
        end
    end

endmodule

// File: rtl/huff_code_builder.sv
// Huffman code-word builder: merge events -> per-symbol code/mask/length tables (HCB_PREPEND_EN selects insert-at-len).
// Latency: lane update and done visible one cycle after the accepting merge.
// Backpressure: merge_ready high only in BUILD and not in a start cycle; merges elsewhere are ignored.
module huff_code_builder
    import huff_pkg::*;
#(
    parameter  int NUM_SYM = HCB_DEF_NUM_SYM,
    parameter  int MAX_LEN = HCB_DEF_MAX_LEN,
    localparam int LEN_W   = len_w_of(MAX_LEN)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       merge_valid,
    output logic                       merge_ready,
    input  logic [NUM_SYM-1:0]         merge_l_mask,
    input  logic [NUM_SYM-1:0]         merge_s_mask,
    input  logic                       merge_last,
    output logic [NUM_SYM*MAX_LEN-1:0] code_flat,
    output logic [NUM_SYM*MAX_LEN-1:0] mask_flat,
    output logic [NUM_SYM*LEN_W-1:0]   len_flat,
    output logic                       done,
    output logic                       overflow
);

    hcb_state_t           state_q;
    hcb_state_t           state_d;
    logic                 lane_clr;
    logic                 fire;
    logic [NUM_SYM-1:0]   lane_ovf;

    // Next state, handshake and clear strobe; start always wins over a merge
    always_comb begin
        state_d     = state_q;
        merge_ready = 1'b0;
        lane_clr    = 1'b0;
        fire        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    lane_clr = 1'b1;
                    state_d  = BUILD;
                end
            end
            BUILD: begin
                if (start) begin
                    lane_clr = 1'b1;
                end else begin
                    merge_ready = reset;
                    fire        = merge_valid & reset;
                    if (fire && merge_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    lane_clr = 1'b1;
                    state_d  = BUILD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky overflow: set by any saturated lane, cleared only by a new table
    always_ff @(posedge clk) begin
        if (!reset || lane_clr) begin
            overflow <= 1'b0;
        end else if (|lane_ovf) begin
            overflow <= 1'b1;
        end
    end

    assign done = (state_q == DONE);

    for (genvar i = 0; i < NUM_SYM; i++) begin : g_lane
        huff_code_lane #(
            .MAX_LEN (MAX_LEN),
            .LEN_W   (LEN_W)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .clr   (lane_clr),
            .upd   (fire),
            .sel_l (merge_l_mask[i]),
            .sel_s (merge_s_mask[i]),
            .code  (code_flat[flat_off(i, MAX_LEN) +: MAX_LEN]),
            .mask  (mask_flat[flat_off(i, MAX_LEN) +: MAX_LEN]),
            .len   (len_flat[flat_off(i, LEN_W) +: LEN_W]),
            .ovf   (lane_ovf[i])
        );
    end

endmodule

// File: tb/tb_huff_code_builder.sv
// Self-checking bench for huff_code_builder: directed table, corner sequences, random vs reference model.
// Latency: outputs checked 1 ns after the edge following each driven cycle.
// Backpressure: merge_ready sampled before each edge and compared to the model's expectation.
module tb_huff_code_builder;

    localparam int NUM_SYM = 6;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic                       merge_valid;
    logic                       merge_ready;
    logic [NUM_SYM-1:0]         merge_l_mask;
    logic [NUM_SYM-1:0]         merge_s_mask;
    logic                       merge_last;
    logic [NUM_SYM*MAX_LEN-1:0] code_flat;
    logic [NUM_SYM*MAX_LEN-1:0] mask_flat;
    logic [NUM_SYM*LEN_W-1:0]   len_flat;
    logic                       done;
    logic                       overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 = idle, 1 = building, 2 = table complete
    int          m_state;
    int unsigned m_code [NUM_SYM];
    int unsigned m_len  [NUM_SYM];
    bit          m_ovf;

    huff_code_builder #(.NUM_SYM(NUM_SYM), .MAX_LEN(MAX_LEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .merge_valid  (merge_valid),
        .merge_ready  (merge_ready),
        .merge_l_mask (merge_l_mask),
        .merge_s_mask (merge_s_mask),
        .merge_last   (merge_last),
        .code_flat    (code_flat),
        .mask_flat    (mask_flat),
        .len_flat     (len_flat),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_SYM; i++) begin
            m_code[i] = 0;
            m_len[i]  = 0;
        end
        m_ovf = 1'b0;
    endtask

    // One clock edge of the specified behaviour, in plain arithmetic
    task automatic model_edge(input bit st, input bit mv, input logic [NUM_SYM-1:0] l,
                              input logic [NUM_SYM-1:0] s, input bit last);
        int unsigned b;
        if (st) begin
            model_clear();
            m_state = 1;
        end else if (m_state == 1 && mv) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                if (l[i] || s[i]) begin
                    b = l[i] ? 0 : 1;
                    if (m_len[i] >= MAX_LEN) begin
                        m_ovf = 1'b1;
                    end else begin
`ifdef HCB_PREPEND_EN
                        m_code[i] = m_code[i] + b * (32'd1 << m_len[i]);
`else
                        m_code[i] = m_code[i] * 2 + b;
`endif
                        m_len[i] = m_len[i] + 1;
                    end
                end
            end
            if (last) m_state = 2;
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < NUM_SYM; i++) begin
            chk($sformatf("%s code[%0d]", tag, i), code_flat[i*MAX_LEN +: MAX_LEN], m_code[i]);
            chk($sformatf("%s mask[%0d]", tag, i), mask_flat[i*MAX_LEN +: MAX_LEN],
                (32'd1 << m_len[i]) - 32'd1);
            chk($sformatf("%s len[%0d]", tag, i), len_flat[i*LEN_W +: LEN_W], m_len[i]);
        end
        chk({tag, " done"}, done, (m_state == 2));
        chk({tag, " overflow"}, overflow, m_ovf);
    endtask

    // Drive one cycle, check ready before the edge, advance model, check outputs after
    task automatic step(input string tag, input bit st, input bit mv,
                        input logic [NUM_SYM-1:0] l, input logic [NUM_SYM-1:0] s,
                        input bit last, output bit rdy_seen);
        start        = st;
        merge_valid  = mv;
        merge_l_mask = l;
        merge_s_mask = s;
        merge_last   = last;
        #1;
        rdy_seen = merge_ready;
        chk({tag, " merge_ready"}, merge_ready, (m_state == 1) && !st);
        @(posedge clk);
        model_edge(st, mv, l, s, last);
        #1;
        compare_all(tag);
    endtask

    typedef struct {
        bit                 st;
        bit                 mv;
        logic [NUM_SYM-1:0] l;
        logic [NUM_SYM-1:0] s;
        bit                 last;
        bit                 exp_rdy;
        bit                 exp_done;
        logic [47:0]        exp_code;
        logic [47:0]        exp_mask;
        logic [23:0]        exp_len;
    } vec_t;

    vec_t vt [4];
    bit   rdy;

    initial begin
        // Two-merge build expectations, written out by hand
        vt[0] = '{1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0,
                  48'h0, 48'h0, 24'h0};
        vt[1] = '{1'b0, 1'b1, 6'b000001, 6'b000010, 1'b0, 1'b1, 1'b0,
                  48'h0000_0000_0100, 48'h0000_0000_0101, 24'h000011};
`ifdef HCB_PREPEND_EN
        vt[2] = '{1'b0, 1'b1, 6'b000011, 6'b000100, 1'b1, 1'b1, 1'b1,
                  48'h0000_0001_0100, 48'h0000_0001_0303, 24'h000122};
        vt[3] = '{1'b0, 1'b1, 6'b111111, 6'b000000, 1'b0, 1'b0, 1'b1,
                  48'h0000_0001_0100, 48'h0000_0001_0303, 24'h000122};
`else
        vt[2] = '{1'b0, 1'b1, 6'b000011, 6'b000100, 1'b1, 1'b1, 1'b1,
                  48'h0000_0001_0200, 48'h0000_0001_0303, 24'h000122};
        vt[3] = '{1'b0, 1'b1, 6'b111111, 6'b000000, 1'b0, 1'b0, 1'b1,
                  48'h0000_0001_0200, 48'h0000_0001_0303, 24'h000122};
`endif

        // Reset held two cycles with start asserted
        reset        = 1'b0;
        start        = 1'b1;
        merge_valid  = 1'b0;
        merge_l_mask = '0;
        merge_s_mask = '0;
        merge_last   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_state = 0;
        model_clear();
        chk("reset merge_ready", merge_ready, 1'b0);
        compare_all("reset");
        reset = 1'b1;
        start = 1'b0;

        // merge_valid in IDLE is ignored
        step("idle_ignore", 1'b0, 1'b1, 6'h3f, 6'h00, 1'b1, rdy);

        // Directed table, run twice: second pass restarts from DONE
        for (int pass = 0; pass < 2; pass++) begin
            for (int r = 0; r < 4; r++) begin
                step($sformatf("tbl%0d.%0d", pass, r), vt[r].st, vt[r].mv, vt[r].l, vt[r].s,
                     vt[r].last, rdy);
                chk($sformatf("tbl%0d.%0d rdy", pass, r), rdy, vt[r].exp_rdy);
                chk($sformatf("tbl%0d.%0d done", pass, r), done, vt[r].exp_done);
                chk($sformatf("tbl%0d.%0d code", pass, r), code_flat, vt[r].exp_code);
                chk($sformatf("tbl%0d.%0d mask", pass, r), mask_flat, vt[r].exp_mask);
                chk($sformatf("tbl%0d.%0d len", pass, r), len_flat, vt[r].exp_len);
            end
        end

        // Both masks set: long subtree wins
        step("prio_start", 1'b1, 1'b0, 6'h00, 6'h00, 1'b0, rdy);
        step("prio_fire", 1'b0, 1'b1, 6'b000001, 6'b000001, 1'b0, rdy);
        chk("prio sym0 code", code_flat[7:0], 8'h00);
        chk("prio sym0 len", len_flat[3:0], 4'd1);

        // Saturation at MAX_LEN and sticky overflow
        step("ovf_start", 1'b1, 1'b0, 6'h00, 6'h00, 1'b0, rdy);
        for (int k = 0; k < 8; k++) begin
            step($sformatf("ovf_fire%0d", k), 1'b0, 1'b1, 6'b000001, 6'h00, 1'b0, rdy);
        end
        chk("ovf len8", len_flat[3:0], 4'd8);
        chk("ovf code8", code_flat[7:0], 8'h00);
        chk("ovf mask8", mask_flat[7:0], 8'hFF);
        chk("ovf flag8", overflow, 1'b0);
        step("ovf_fire8", 1'b0, 1'b1, 6'b000001, 6'h00, 1'b0, rdy);
        chk("ovf flag9", overflow, 1'b1);
        chk("ovf len9", len_flat[3:0], 4'd8);
        chk("ovf mask9", mask_flat[7:0], 8'hFF);
        step("ovf_idle", 1'b0, 1'b0, 6'h00, 6'h00, 1'b0, rdy);
        chk("ovf sticky", overflow, 1'b1);
        step("ovf_clear", 1'b1, 1'b0, 6'h00, 6'h00, 1'b0, rdy);
        chk("ovf cleared", overflow, 1'b0);

        // Abort mid-BUILD with a merge offered in the same cycle
        step("abort_fill", 1'b0, 1'b1, 6'b000011, 6'b110000, 1'b0, rdy);
        step("abort", 1'b1, 1'b1, 6'h3f, 6'h00, 1'b0, rdy);
        chk("abort rdy", rdy, 1'b0);
        chk("abort lanes", len_flat, 24'h0);
        step("abort_next", 1'b0, 1'b1, 6'h00, 6'b000100, 1'b0, rdy);
        chk("abort next rdy", rdy, 1'b1);
        chk("abort next sym2", code_flat[23:16], 8'h01);
        chk("abort next len", len_flat, 24'h000100);

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            step($sformatf("rnd%0d", n),
                 ($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)),
                 NUM_SYM'($urandom & $urandom & $urandom),
                 NUM_SYM'($urandom & $urandom),
                 ($urandom_range(0, 29) == 0),
                 rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
